// File: rtl/axis_rgb_to_gray.sv
// Purpose : AXI4-Stream pixel stage, 24-bit RGB in -> 8-bit luma replicated on R/G/B out,
//           with SOF tagging, line-length checking and frame-end pulse.
// Latency : two registered stages; a beat presented in cycle c is on m00_axis_* in cycle c+2.
// Backpr. : each stage advances when its downstream slot is empty or draining; at most two
//           beats are absorbed while m00_axis_tready is low, s00_axis_tready follows it combinationally.
//
// Ports:
//   axis_aclk        clock for both stream interfaces
//   axis_areset      synchronous, active-high reset
//   s00_axis_*       input pixel stream: tdata[23:16]=R, [15:8]=G, [7:0]=B, [31:24]/tstrb ignored,
//                    tlast marks the last pixel of a line
//   m00_axis_*       output stream: tdata={8'h00,Y,Y,Y}, tstrb all ones, tlast = input tlast,
//                    tuser = first pixel of a frame
//   len_err          sticky: a line ended with tlast at the wrong column, or ran past the width
//   frame_done       one-cycle pulse on the output handshake of the last pixel of a frame
module axis_rgb_to_gray #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int IMAGE_WIDTH            = 640,
   parameter int IMAGE_HEIGHT           = 480,
   parameter int COEF_R                 = 77,
   parameter int COEF_G                 = 150,
   parameter int COEF_B                 = 29
) (
   input  logic                                  axis_aclk,
   input  logic                                  axis_areset,

   input  logic                                  s00_axis_tvalid,
   output logic                                  s00_axis_tready,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                  s00_axis_tlast,

   output logic                                  m00_axis_tvalid,
   input  logic                                  m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic                                  m00_axis_tlast,
   output logic                                  m00_axis_tuser,

   output logic                                  len_err,
   output logic                                  frame_done
);

   // Only the 32-bit stream width is meaningful for this stage; the width
   // parameters exist so the block drops into the existing stream fabric.

   localparam logic [9:0]  LAST_COL = 10'(IMAGE_WIDTH - 1);
   localparam logic [8:0]  LAST_ROW = 9'(IMAGE_HEIGHT - 1);

   // Coefficients are held at 16 bits so each product is a clean 16x16->16
   // multiply; the weights sum to 256 so every product fits in 16 bits.
   localparam logic [15:0] K_R = 16'(COEF_R);
   localparam logic [15:0] K_G = 16'(COEF_G);
   localparam logic [15:0] K_B = 16'(COEF_B);

   // Stage-1 payload: weighted colour products plus the per-beat sideband.
   typedef struct packed {
      logic [15:0] prod_r;
      logic [15:0] prod_g;
      logic [15:0] prod_b;
      logic        last;
      logic        sof;
      logic        eof;
   } s1_t;

   s1_t         s1_dat;
   logic        s1_vld;
   logic        s2_eof;

   logic        s1_adv;
   logic        s2_adv;
   logic        in_hs;
   logic        out_hs;

   logic [9:0]  col_cnt;
   logic [8:0]  row_cnt;
   logic        at_last_col;
   logic        at_last_row;
   logic        line_end;
   logic        in_sof;
   logic        in_eof;

   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;

   logic [16:0] luma_sum;
   logic [7:0]  luma;

   logic        unused_bits;

   // ------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------
   // Stage 2 (the output register) can take new data when empty or when the
   // current beat leaves this cycle; stage 1 likewise relative to stage 2.
   assign s2_adv = !m00_axis_tvalid || m00_axis_tready;
   assign s1_adv = !s1_vld || s2_adv;

   // Held low during reset so nothing is accepted into a pipeline that is
   // being cleared.
   assign s00_axis_tready = s1_adv && !axis_areset;

   assign in_hs  = s00_axis_tvalid && s00_axis_tready;
   assign out_hs = m00_axis_tvalid && m00_axis_tready;

   // ------------------------------------------------------------------
   // Frame position tracking
   // ------------------------------------------------------------------
   assign at_last_col = (col_cnt == LAST_COL);
   assign at_last_row = (row_cnt == LAST_ROW);

   // A line closes either on the upstream tlast or, if tlast never comes,
   // on reaching the configured width, so one bad line cannot shift the
   // row count of the rest of the frame.
   assign line_end = s00_axis_tlast || at_last_col;
   assign in_sof   = (row_cnt == 9'd0) && (col_cnt == 10'd0);
   assign in_eof   = line_end && at_last_row;

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         col_cnt <= '0;
         row_cnt <= '0;
         len_err <= 1'b0;
      end else if (in_hs) begin
         if (line_end) begin
            col_cnt <= '0;
            row_cnt <= at_last_row ? 9'd0 : row_cnt + 9'd1;
            // tlast and the width counter disagree: short line (tlast early)
            // or long line (width reached without tlast).
            if (s00_axis_tlast != at_last_col) begin
               len_err <= 1'b1;
            end
         end else begin
            col_cnt <= col_cnt + 10'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: weighted products
   // ------------------------------------------------------------------
   assign pix_r = s00_axis_tdata[23:16];
   assign pix_g = s00_axis_tdata[15:8];
   assign pix_b = s00_axis_tdata[7:0];

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else if (s1_adv) begin
         s1_vld <= s00_axis_tvalid;
         // s1_adv with tvalid outside reset is exactly an input handshake.
         if (s00_axis_tvalid) begin
            s1_dat.prod_r <= K_R * {8'h00, pix_r};
            s1_dat.prod_g <= K_G * {8'h00, pix_g};
            s1_dat.prod_b <= K_B * {8'h00, pix_b};
            s1_dat.last   <= s00_axis_tlast;
            s1_dat.sof    <= in_sof;
            s1_dat.eof    <= in_eof;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: sum, round to nearest, scale by 1/256
   // ------------------------------------------------------------------
   // With weights summing to 256 the rounded sum is at most 255*256+128,
   // so bit 16 is always zero and Y needs no saturation.
   assign luma_sum = {1'b0, s1_dat.prod_r}
                   + {1'b0, s1_dat.prod_g}
                   + {1'b0, s1_dat.prod_b}
                   + 17'd128;
   assign luma     = luma_sum[15:8];

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tuser  <= 1'b0;
         s2_eof          <= 1'b0;
      end else if (s2_adv) begin
         m00_axis_tvalid <= s1_vld;
         // Payload only loads with a real beat, so the outputs hold their
         // value through any stall.
         if (s1_vld) begin
            m00_axis_tdata <= {8'h00, luma, luma, luma};
            m00_axis_tlast <= s1_dat.last;
            m00_axis_tuser <= s1_dat.sof;
            s2_eof         <= s1_dat.eof;
         end
      end
   end

   assign m00_axis_tstrb = '1;

   // Pulses in the cycle the last pixel of the frame is taken downstream.
   assign frame_done = out_hs && s2_eof && !axis_areset;

   // Input bits that carry nothing for this stage, and the always-zero top
   // bit of the rounded sum.
   assign unused_bits = ^{s00_axis_tstrb,
                          s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:24],
                          luma_sum[16]};

endmodule

// File: tb/tb_axis_rgb_to_gray.sv
module tb_axis_rgb_to_gray;

   localparam int W = 8;
   localparam int H = 4;

   logic        axis_aclk = 1'b0;
   logic        axis_areset;
   logic        s00_axis_tvalid;
   logic        s00_axis_tready;
   logic [31:0] s00_axis_tdata;
   logic [3:0]  s00_axis_tstrb;
   logic        s00_axis_tlast;
   logic        m00_axis_tvalid;
   logic        m00_axis_tready;
   logic [31:0] m00_axis_tdata;
   logic [3:0]  m00_axis_tstrb;
   logic        m00_axis_tlast;
   logic        m00_axis_tuser;
   logic        len_err;
   logic        frame_done;

   typedef struct packed {
      logic [31:0] cyc;
      logic        fd;
      logic        user;
      logic        last;
      logic [31:0] dat;
   } beat_t;

   beat_t       out_q[$];
   int          n_chk    = 0;
   int          n_pass   = 0;
   int          acc_cnt  = 0;
   int          fd_total = 0;
   int          cyc      = 0;
   logic        stall_prev = 1'b0;
   logic [33:0] stall_dat  = '0;

   // Hand-computed colour vectors: Y = (77R + 150G + 29B + 128) >> 8.
   logic [31:0] col_in  [4];
   logic [31:0] col_exp [4];

   axis_rgb_to_gray #(
      .C_S00_AXIS_TDATA_WIDTH (32),
      .C_M00_AXIS_TDATA_WIDTH (32),
      .IMAGE_WIDTH            (W),
      .IMAGE_HEIGHT           (H),
      .COEF_R                 (77),
      .COEF_G                 (150),
      .COEF_B                 (29)
   ) dut (
      .axis_aclk       (axis_aclk),
      .axis_areset     (axis_areset),
      .s00_axis_tvalid (s00_axis_tvalid),
      .s00_axis_tready (s00_axis_tready),
      .s00_axis_tdata  (s00_axis_tdata),
      .s00_axis_tstrb  (s00_axis_tstrb),
      .s00_axis_tlast  (s00_axis_tlast),
      .m00_axis_tvalid (m00_axis_tvalid),
      .m00_axis_tready (m00_axis_tready),
      .m00_axis_tdata  (m00_axis_tdata),
      .m00_axis_tstrb  (m00_axis_tstrb),
      .m00_axis_tlast  (m00_axis_tlast),
      .m00_axis_tuser  (m00_axis_tuser),
      .len_err         (len_err),
      .frame_done      (frame_done)
   );

   initial forever #5 axis_aclk = ~axis_aclk;
   initial forever begin @(posedge axis_aclk); cyc++; end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Grey input (R=G=B=v) has luma exactly v; top byte is junk to be ignored.
   function automatic logic [31:0] px(input logic [7:0] v);
      return {8'hA5, v, v, v};
   endfunction

   function automatic logic [31:0] grey(input logic [7:0] v);
      return {8'h00, v, v, v};
   endfunction

   // Output monitor: records every output handshake, counts input handshakes
   // and frame_done pulses, and checks that a stalled beat holds still.
   initial forever begin
      @(negedge axis_aclk);
      if (axis_areset) begin
         stall_prev = 1'b0;
      end else begin
         if (s00_axis_tvalid && s00_axis_tready) acc_cnt++;
         if (frame_done) fd_total++;
         if (stall_prev) begin
            chk("hold_vld", m00_axis_tvalid, 1'b1);
            chk("hold_dat", {m00_axis_tuser, m00_axis_tlast, m00_axis_tdata}, stall_dat);
         end
         if (m00_axis_tvalid && m00_axis_tready) begin
            beat_t b;
            b.cyc  = cyc;
            b.fd   = frame_done;
            b.user = m00_axis_tuser;
            b.last = m00_axis_tlast;
            b.dat  = m00_axis_tdata;
            out_q.push_back(b);
         end
         stall_prev = m00_axis_tvalid && !m00_axis_tready;
         stall_dat  = {m00_axis_tuser, m00_axis_tlast, m00_axis_tdata};
      end
   end

   // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      s00_axis_tvalid = 1'b1;
      s00_axis_tdata  = d;
      s00_axis_tlast  = l;
      s00_axis_tstrb  = 4'h3;
      n = 0;
      @(negedge axis_aclk);
      while (!s00_axis_tready && n < 200) begin
         n++;
         @(negedge axis_aclk);
      end
      if (!s00_axis_tready) chk("send_timeout", 1'b0, 1'b1);
      @(posedge axis_aclk);
      #1;
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
   endtask

   task automatic send_run(input int base, input int n, input int len);
      for (int i = 0; i < n; i++) send(px(8'(base + i)), (i % len) == len - 1);
   endtask

   task automatic do_reset();
      @(posedge axis_aclk);
      #1;
      axis_areset     = 1'b1;
      s00_axis_tvalid = 1'b0;
      repeat (2) @(posedge axis_aclk);
      #1;
      axis_areset = 1'b0;
      out_q.delete();
      acc_cnt  = 0;
      fd_total = 0;
   endtask

   task automatic wait_out(input string tag, input int n);
      for (int i = 0; i < 300 && out_q.size() < n; i++) @(posedge axis_aclk);
      repeat (4) @(posedge axis_aclk);
      #1;
      chk(tag, out_q.size(), n);
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [7:0] v, input logic l);
      if (idx < out_q.size()) begin
         chk({tag, "_dat"}, out_q[idx].dat, grey(v));
         chk({tag, "_last"}, out_q[idx].last, l);
      end else begin
         chk({tag, "_missing"}, 1'b0, 1'b1);
      end
   endtask

   initial begin
      col_in[0]  = 32'h00FFFFFF; col_exp[0] = 32'h00FFFFFF;
      col_in[1]  = 32'h00640000; col_exp[1] = 32'h001E1E1E;
      col_in[2]  = 32'h0000C800; col_exp[2] = 32'h00757575;
      col_in[3]  = 32'h000000FF; col_exp[3] = 32'h001D1D1D;

      axis_areset     = 1'b1;
      s00_axis_tvalid = 1'b0;
      s00_axis_tdata  = '0;
      s00_axis_tstrb  = '0;
      s00_axis_tlast  = 1'b0;
      m00_axis_tready = 1'b1;

      // Reset state
      @(negedge axis_aclk);
      chk("rst_s_rdy", s00_axis_tready, 1'b0);
      chk("rst_m_vld", m00_axis_tvalid, 1'b0);
      @(posedge axis_aclk);
      #1;
      axis_areset = 1'b0;
      @(negedge axis_aclk);
      chk("rst_s_rdy_after", s00_axis_tready, 1'b1);
      chk("rst_m_vld_after", m00_axis_tvalid, 1'b0);
      chk("rst_tdata", m00_axis_tdata, 32'h0);
      chk("rst_tlast", m00_axis_tlast, 1'b0);
      chk("rst_tuser", m00_axis_tuser, 1'b0);
      chk("rst_len_err", len_err, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("tstrb", m00_axis_tstrb, 4'hF);
      @(posedge axis_aclk);
      #1;

      // Colour conversion and two-cycle latency
      for (int i = 0; i < 4; i++) begin
         send(col_in[i], 1'b0);
         @(negedge axis_aclk);
         chk("colour_early", m00_axis_tvalid, 1'b0);
         @(negedge axis_aclk);
         chk("colour_vld", m00_axis_tvalid, 1'b1);
         chk("colour_dat", m00_axis_tdata, col_exp[i]);
         chk("colour_user", m00_axis_tuser, i == 0);
         @(posedge axis_aclk);
         #1;
      end

      // Full line with downstream ready toggling every cycle
      do_reset();
      fork
         send_run(8'h20, 8, W);
         begin
            for (int g = 0; g < 300 && out_q.size() < 8; g++) begin
               @(posedge axis_aclk);
               #1;
               m00_axis_tready = !m00_axis_tready;
            end
            m00_axis_tready = 1'b1;
         end
      join
      wait_out("toggle_count", 8);
      for (int i = 0; i < 8; i++) chk_beat("toggle", i, 8'(8'h20 + i), i == 7);
      if (out_q.size() > 0) chk("toggle_sof", out_q[0].user, 1'b1);

      // Downstream stall with continuous input
      do_reset();
      m00_axis_tready = 1'b0;
      fork
         send_run(8'h30, 6, W);
         begin
            repeat (10) @(posedge axis_aclk);
            #2;
            chk("stall_accepted", acc_cnt, 2);
            chk("stall_s_rdy", s00_axis_tready, 1'b0);
            chk("stall_m_vld", m00_axis_tvalid, 1'b1);
            @(posedge axis_aclk);
            #1;
            m00_axis_tready = 1'b1;
            @(negedge axis_aclk);
            chk("recover_s_rdy", s00_axis_tready, 1'b1);
         end
      join
      wait_out("stall_count", 6);
      for (int i = 0; i < 6; i++) chk_beat("stall", i, 8'(8'h30 + i), 1'b0);
      if (out_q.size() == 6) chk("stall_thruput", out_q[5].cyc - out_q[0].cyc, 5);

      // Short line, then the rest of the frame must line up from col 0 of row 1
      do_reset();
      send_run(8'h40, 4, W);
      chk("short_no_err_yet", len_err, 1'b0);
      send(px(8'h44), 1'b1);
      chk("short_len_err", len_err, 1'b1);
      send_run(8'h80, 25, W);
      wait_out("short_count", 30);
      for (int i = 0; i < 30; i++) begin
         if (i < 5) chk_beat("short", i, 8'(8'h40 + i), i == 4);
         else       chk_beat("short", i, 8'(8'h80 + i - 5), ((i - 5) % 8) == 7);
      end
      if (out_q.size() == 30) begin
         chk("short_sof0", out_q[0].user, 1'b1);
         chk("short_fd_beat", out_q[28].fd, 1'b1);
         chk("short_next_sof", out_q[29].user, 1'b1);
      end
      chk("short_fd_total", fd_total, 1);
      chk("short_len_err_sticky", len_err, 1'b1);

      // Four full lines plus the first pixel of the next frame
      do_reset();
      send_run(1, 33, W);
      wait_out("frame_count", 33);
      for (int i = 0; i < 33; i++) begin
         chk_beat("frame", i, 8'(1 + i), (i % 8) == 7);
         if (i < out_q.size()) begin
            chk("frame_user", out_q[i].user, (i == 0) || (i == 32));
            chk("frame_fd", out_q[i].fd, i == 31);
         end
      end
      chk("frame_fd_total", fd_total, 1);
      chk("frame_len_err", len_err, 1'b0);

      // Reset in the middle of a line with len_err already set
      do_reset();
      send(px(8'h50), 1'b1);
      send_run(8'h58, 3, W);
      chk("mid_pre_len_err", len_err, 1'b1);
      do_reset();
      @(negedge axis_aclk);
      chk("mid_m_vld", m00_axis_tvalid, 1'b0);
      chk("mid_len_err", len_err, 1'b0);
      @(posedge axis_aclk);
      #1;
      send_run(8'h60, 8, W);
      wait_out("mid_count", 8);
      for (int i = 0; i < 8; i++) chk_beat("mid", i, 8'(8'h60 + i), i == 7);
      if (out_q.size() > 0) chk("mid_sof", out_q[0].user, 1'b1);
      chk("mid_len_err_end", len_err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
